note_sequencer: RTL

Score player that walks a melody ROM and drives the `note`/`pitch`/`enable` inputs of the downstream `Buzzer` tone generator. Each ROM word names a note (or rest) and its length in sixteenth-note ticks. The sequencer holds the note for that many ticks, then fetches the next word, until an end marker is reached. It sits between the score ROM and `Buzzer`, with start/stop/loop controls coming from the user-input logic.

---
 rtl/noteseq_pkg.sv | 37 +++
 rtl/note_sequencer_tick_gen.sv | 32 +++
 rtl/note_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/noteseq_pkg.sv
// noteseq_pkg: shared types and constants for the note sequencer.
//   - seq_state_t   : sequencer state encoding (ST_GAP only with NOTESEQ_GAP_EN)
//   - *_BIT/*_LSB   : score ROM word field positions
//   - PITCH_*       : octave codes driven to the Buzzer
//   - degree_to_onehot : degree (0=rest, 1..7=C..B) to one-hot note bus
package noteseq_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned END_BIT   = 15;
  localparam int unsigned PITCH_LSB = 13;
  localparam int unsigned DEG_LSB   = 10;
  localparam int unsigned RSVD_LSB  = 8;
  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned LEN_W     = 8;

  localparam logic [1:0] PITCH_LOW  = 2'd0;
  localparam logic [1:0] PITCH_MID  = 2'd1;
  localparam logic [1:0] PITCH_HIGH = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
`ifdef NOTESEQ_GAP_EN
    ST_GAP,
`endif
    ST_PLAY
  } seq_state_t;

  // Degree 0 is a rest (silent); 1..7 map to bits 0..6, bit 7 never set.
  function automatic logic [7:0] degree_to_onehot(input logic [2:0] deg);
    if (deg == 3'd0) return 8'h00;
    return 8'(8'h01 << (deg - 3'd1));
  endfunction

endpackage

// File: rtl/note_sequencer_tick_gen.sv
// tick_gen: TICK_DIV prescaler with synchronous clear.
//   CLK, RSTn : clock, async active-low reset
//   clr       : synchronous clear; count returns to 0, tick suppressed
//   tick      : high for the one cycle in which count == TICK_DIV-1
//   count     : current prescaler count (0 .. TICK_DIV-1)
module tick_gen #(
  parameter int unsigned TICK_DIV = 6_250_000
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        clr,
  output logic                        tick,
  output logic [$clog2(TICK_DIV)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  // tick is registered: raised one cycle ahead so it lines up with the last count.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= (count == CNT_W'(TICK_DIV - 1)) ? '0 : count + CNT_W'(1);
      tick  <= (count == CNT_W'(TICK_DIV - 2));
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: walks a score ROM and drives the Buzzer note/pitch/enable.
//   CLK, RSTn   : clock, async active-low reset
//   start, stop : single-cycle controls (stop wins); loop : restart on END
//   rom_addr    : score ROM address; rom_data : word, valid one cycle later
//   note, pitch, enable : Buzzer controls
//   busy        : not idle; done : one-cycle pulse at non-looped end of score
// Optional: NOTESEQ_GAP_EN silences the last GAP_CYC cycles of each note.
module note_sequencer
  import noteseq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 6_250_000,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned GAP_CYC  = 500_000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [7:0]        note,
  output logic [1:0]        pitch,
  output logic              enable,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W  = $clog2(TICK_DIV);
  localparam int unsigned GAP_AT = TICK_DIV - GAP_CYC - 1;

  seq_state_t        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  ticks_q;
  logic              tick;
  logic [CNT_W-1:0]  tick_count;

  logic              playing_c;
  logic              last_tick_c;
  logic              gap_hit_c;
  logic [2:0]        deg_c;
  logic [1:0]        pitch_c;
  logic [LEN_W-1:0]  len_c;
  logic              rsvd_unused_c;

  // Prescaler runs only while a note is sounding, so it restarts at PLAY entry.
`ifdef NOTESEQ_GAP_EN
  assign playing_c = (state == ST_PLAY) || (state == ST_GAP);
`else
  assign playing_c = (state == ST_PLAY);
`endif

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .clr   (!playing_c),
    .tick  (tick),
    .count (tick_count)
  );

  // Word field extraction; reserved bits are deliberately ignored.
  assign deg_c         = rom_data[DEG_LSB +: 3];
  assign pitch_c       = (rom_data[PITCH_LSB +: 2] == 2'd3) ? PITCH_MID : rom_data[PITCH_LSB +: 2];
  assign len_c         = (rom_data[LEN_LSB +: LEN_W] == '0) ? LEN_W'(1) : rom_data[LEN_LSB +: LEN_W];
  assign rsvd_unused_c = ^rom_data[RSVD_LSB +: 2];

  assign last_tick_c = (ticks_q == len_q - LEN_W'(1));
  assign gap_hit_c   = last_tick_c && (tick_count == CNT_W'(GAP_AT));

`ifndef NOTESEQ_GAP_EN
  logic gap_unused_c;
  assign gap_unused_c = gap_hit_c;
`endif

  // Sequencer FSM with registered Buzzer outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      rom_addr <= '0;
      note     <= '0;
      pitch    <= PITCH_LOW;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_q    <= LEN_W'(1);
      ticks_q  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= ST_IDLE;
        rom_addr <= '0;
        note     <= '0;
        pitch    <= PITCH_LOW;
        enable   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state    <= ST_FETCH;
              rom_addr <= '0;
              busy     <= 1'b1;
            end
          end
          ST_FETCH: state <= ST_WAIT;
          ST_WAIT:  state <= ST_DECODE;
          ST_DECODE: begin
            if (rom_data[END_BIT]) begin
              if (loop) begin
                rom_addr <= '0;
                state    <= ST_FETCH;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end else begin
              len_q   <= len_c;
              ticks_q <= '0;
              note    <= degree_to_onehot(deg_c);
              pitch   <= pitch_c;
              enable  <= (deg_c != 3'd0);
              state   <= ST_PLAY;
            end
          end
          ST_PLAY: begin
`ifdef NOTESEQ_GAP_EN
            if (gap_hit_c) begin
              enable <= 1'b0;
              state  <= ST_GAP;
            end else
`endif
            if (tick) begin
              if (last_tick_c) begin
                enable   <= 1'b0;
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= ST_FETCH;
              end else begin
                ticks_q <= ticks_q + LEN_W'(1);
              end
            end
          end
`ifdef NOTESEQ_GAP_EN
          ST_GAP: begin
            if (tick) begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= ST_FETCH;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
